key_move_queue: RTL and testbench

Buffers the single-cycle direction pulses from the key edge detector and turns them into a valid/ready stream of 2-bit move codes for the game core. It accepts at most one move per press event using an UP > DOWN > LEFT > RIGHT priority, and applies a lockout window after each accepted move to reject contact bounce. Moves are queued in a small FIFO, so presses arriving while the core is busy are kept, not lost. Overflow is reported through a sticky flag and a saturating drop counter.

---
 rtl/key_move_queue_if.sv | 10 +
 rtl/key_move_queue.sv | 86 ++++++++
 tb/tb_key_move_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/key_move_queue_if.sv
// Move-code stream from key_move_queue to the game core.
// Producer drives code/valid, consumer drives ready.
interface key_move_queue_if;
  logic [1:0] KMQ_dir_code;
  logic       KMQ_dir_valid;
  logic       KMQ_dir_ready;

  modport master (output KMQ_dir_code, output KMQ_dir_valid, input KMQ_dir_ready);
  modport slave  (input KMQ_dir_code, input KMQ_dir_valid, output KMQ_dir_ready);
endinterface

// File: rtl/key_move_queue.sv
// Debounced direction pulses -> FWFT queue of 2-bit moves; 1-cycle latency.
// Backpressure: moves wait in the FIFO while ready is low; a capture into a full FIFO is dropped and counted.
module key_move_queue #(
  parameter int DEPTH   = 4,
  parameter int LOCKOUT = 250000,
  parameter int CNT_W   = 18
) (
  input  logic                    KMQ_clk,
  input  logic                    KMQ_rst,
  input  logic                    KMQ_up_action,
  input  logic                    KMQ_down_action,
  input  logic                    KMQ_left_action,
  input  logic                    KMQ_right_action,
  input  logic                    KMQ_clear,
  key_move_queue_if.master        kmq_if,
  output logic [$clog2(DEPTH):0]  KMQ_level,
  output logic                    KMQ_overflow,
  output logic [7:0]              KMQ_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [1:0]       mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] lock_cnt;
  logic             any_act;
  logic             capture;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             flush;
  logic [1:0]       cap_code;

  always_comb begin
    any_act = KMQ_up_action | KMQ_down_action | KMQ_left_action | KMQ_right_action;
    capture = any_act && (lock_cnt == '0);
    if (KMQ_up_action)        cap_code = 2'b00;
    else if (KMQ_down_action) cap_code = 2'b01;
    else if (KMQ_left_action) cap_code = 2'b10;
    else                      cap_code = 2'b11;
    flush = KMQ_rst || KMQ_clear;
    full  = (KMQ_level == LW'(DEPTH));
    pop   = kmq_if.KMQ_dir_valid && kmq_if.KMQ_dir_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    push  = capture && (!full || pop);
    drop  = capture && full && !pop;
  end

  assign kmq_if.KMQ_dir_valid = (KMQ_level != '0);
  assign kmq_if.KMQ_dir_code  = kmq_if.KMQ_dir_valid ? mem[rd_ptr] : 2'b00;

  always_ff @(posedge KMQ_clk) begin
    if (push && !flush) mem[wr_ptr] <= cap_code;
  end

  always_ff @(posedge KMQ_clk) begin
    if (flush) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      KMQ_level    <= '0;
      lock_cnt     <= '0;
      KMQ_overflow <= 1'b0;
      KMQ_drop_cnt <= 8'd0;
    end else begin
      // Reloads on every capture, including a dropped one.
      if (capture)              lock_cnt <= CNT_W'(LOCKOUT);
      else if (lock_cnt != '0)  lock_cnt <= lock_cnt - CNT_W'(1);

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   KMQ_level <= KMQ_level + LW'(1);
        2'b01:   KMQ_level <= KMQ_level - LW'(1);
        default: KMQ_level <= KMQ_level;
      endcase

      if (drop) begin
        KMQ_overflow <= 1'b1;
        if (KMQ_drop_cnt != 8'hFF) KMQ_drop_cnt <= KMQ_drop_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_key_move_queue.sv
// Random + directed bench for key_move_queue against a queue-based reference model.
module tb_key_move_queue;
  localparam int DEPTH   = 4;
  localparam int LOCKOUT = 4;
  localparam int CNT_W   = 18;

  logic       clk = 1'b0;
  logic       rst, clr, up_a, dn_a, lf_a, rt_a, rdy;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  key_move_queue_if kmq_if();
  assign kmq_if.KMQ_dir_ready = rdy;

  key_move_queue #(.DEPTH(DEPTH), .LOCKOUT(LOCKOUT), .CNT_W(CNT_W)) dut (
    .KMQ_clk          (clk),
    .KMQ_rst          (rst),
    .KMQ_up_action    (up_a),
    .KMQ_down_action  (dn_a),
    .KMQ_left_action  (lf_a),
    .KMQ_right_action (rt_a),
    .KMQ_clear        (clr),
    .kmq_if           (kmq_if),
    .KMQ_level        (level),
    .KMQ_overflow     (ovf),
    .KMQ_drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of codes plus the earliest edge index at which a capture is allowed.
  logic [1:0] mq[$];
  bit         m_ovf = 1'b0;
  int         m_drops = 0;
  longint     cyc = 0;
  longint     m_next_ok = 0;
  bit         m_pop, m_cap;
  logic [1:0] m_code;

  always @(posedge clk) begin
    if (rst || clr) begin
      mq.delete();
      m_ovf     = 1'b0;
      m_drops   = 0;
      m_next_ok = cyc + 1;
    end else begin
      m_pop = (mq.size() != 0) && rdy;
      m_cap = (up_a || dn_a || lf_a || rt_a) && (cyc >= m_next_ok);
      m_code = up_a ? 2'd0 : dn_a ? 2'd1 : lf_a ? 2'd2 : 2'd3;
      if (m_pop) void'(mq.pop_front());
      if (m_cap) begin
        m_next_ok = cyc + LOCKOUT + 1;
        if (mq.size() < DEPTH) mq.push_back(m_code);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] exp_code;
      exp_code = 2'b00;
      if (mq.size() != 0) exp_code = mq[0];
      chk("m_valid", 32'(kmq_if.KMQ_dir_valid), 32'(mq.size() != 0));
      chk("m_code", 32'(kmq_if.KMQ_dir_code), 32'(exp_code));
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_overflow", 32'(ovf), 32'(m_ovf));
      chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
    end
  end

  task automatic step(input bit u, d, l, r, c, rd, rs);
    up_a = u; dn_a = d; lf_a = l; rt_a = r; clr = c; rdy = rd; rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"}, 32'(kmq_if.KMQ_dir_code), 32'd0);
    chk({tag, "_valid"}, 32'(kmq_if.KMQ_dir_valid), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_drops"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    logic [1:0] drain_exp [4];
    drain_exp[0] = 2'd1; drain_exp[1] = 2'd2; drain_exp[2] = 2'd3; drain_exp[3] = 2'd1;

    step(0, 0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk_all_zero("reset");

    // Single right pulse, then one pop.
    step(0, 0, 0, 1, 0, 0, 0);
    chk("right_valid", 32'(kmq_if.KMQ_dir_valid), 32'd1);
    chk("right_code", 32'(kmq_if.KMQ_dir_code), 32'd3);
    chk("right_level", 32'(level), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("pop_valid", 32'(kmq_if.KMQ_dir_valid), 32'd0);
    chk("pop_level", 32'(level), 32'd0);
    idle(4);

    // Lockout: up at edge 0, down at 2 (ignored) and 5 (captured).
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("lock_level", 32'(level), 32'd2);
    chk("lock_head", 32'(kmq_if.KMQ_dir_code), 32'd0);
    chk("lock_drops", 32'(drop_cnt), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("lock_second", 32'(kmq_if.KMQ_dir_code), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Simultaneous up/left/right -> one up entry.
    step(1, 0, 1, 1, 0, 0, 0);
    chk("prio_level", 32'(level), 32'd1);
    chk("prio_code", 32'(kmq_if.KMQ_dir_code), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Overflow with six left pulses, then clear.
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 0, 0, 0);
      idle(4);
    end
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    step(0, 0, 0, 0, 1, 0, 0);
    chk_all_zero("clear");

    // Full FIFO with simultaneous pop and push, then drain across pointer wrap.
    step(1, 0, 0, 0, 0, 0, 0); idle(4);
    step(0, 1, 0, 0, 0, 0, 0); idle(4);
    step(0, 0, 1, 0, 0, 0, 0); idle(4);
    step(0, 0, 0, 1, 0, 0, 0); idle(4);
    chk("full_level", 32'(level), 32'd4);
    step(0, 1, 0, 0, 0, 1, 0);
    chk("fullpp_level", 32'(level), 32'd4);
    chk("fullpp_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_code", 32'(kmq_if.KMQ_dir_code), 32'(drain_exp[i]));
      step(0, 0, 0, 0, 0, 1, 0);
    end
    chk("drain_level", 32'(level), 32'd0);
    idle(1);

    // Reset mid-stream with level 3 and lockout running.
    step(1, 0, 0, 0, 0, 0, 0); idle(4);
    step(0, 1, 0, 0, 0, 0, 0); idle(4);
    step(0, 0, 1, 0, 0, 0, 0); idle(1);
    chk("pre_rst_level", 32'(level), 32'd3);
    step(1, 0, 0, 0, 0, 1, 1);
    chk_all_zero("midrst");
    step(1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", 32'(kmq_if.KMQ_dir_valid), 32'd1);
    chk("post_rst_code", 32'(kmq_if.KMQ_dir_code), 32'd0);
    chk("post_rst_level", 32'(level), 32'd1);

    // Randomized traffic; the per-cycle model compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] acts;
      acts = 4'b0;
      if ($urandom_range(0, 99) < 35) acts = 4'($urandom_range(1, 15));
      step(acts[0], acts[1], acts[2], acts[3],
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 299) == 0);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
